// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side signal bundle for the 2-way instruction cache.
interface icache_2way_if;
  logic        fetch_enable;
  logic [31:0] pc;
  logic        flush;
  logic        hit;
  logic [31:0] hit_data;
  logic        busy;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;

  // Cache side.
  modport slave (
    input  fetch_enable, pc, flush, mem_valid, mem_data,
    output hit, hit_data, busy, mem_enable, mem_addr
  );

  // Fetch unit / memory controller side.
  modport master (
    output fetch_enable, pc, flush, mem_valid, mem_data,
    input  hit, hit_data, busy, mem_enable, mem_addr
  );
endinterface

// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache: combinational hits, LRU replacement,
// word-at-a-time line refill with first-word bypass, whole-cache flush.
module icache_2way #(
  parameter int unsigned INDEX_BITS    = 6,
  parameter int unsigned WORD_OFF_BITS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  icache_2way_if.slave cif
);

  localparam int unsigned OFF     = WORD_OFF_BITS + 2;
  localparam int unsigned TAG_LSB = OFF + INDEX_BITS;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;
  localparam int unsigned SETS    = 1 << INDEX_BITS;
  localparam int unsigned WORDS   = 1 << WORD_OFF_BITS;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                   state_q, state_d;
  logic                     mem_enable_q, mem_enable_d;
  logic [31:0]              mem_addr_q, mem_addr_d;
  logic                     busy_q, busy_d;
  logic [TAG_W-1:0]         fill_tag_q, fill_tag_d;
  logic [INDEX_BITS-1:0]    fill_index_q, fill_index_d;
  logic [31:0]              buf_q [WORDS];
  logic [31:0]              buf_d [WORDS];

  logic [31:0]              data_q  [2][SETS][WORDS];
  logic [TAG_W-1:0]         tag_q   [2][SETS];
  logic [SETS-1:0]          valid_q [2];
  logic [SETS-1:0]          lru_q;

  logic [INDEX_BITS-1:0]    idx_c;
  logic [WORD_OFF_BITS-1:0] wrd_c;
  logic [TAG_W-1:0]         tag_c;
  logic [WORD_OFF_BITS-1:0] slot_c;
  logic [1:0]               way_hit_c;
  logic                     bypass_c;
  logic                     install_c;
  logic                     victim_c;

  assign idx_c  = cif.pc[TAG_LSB-1:OFF];
  assign wrd_c  = cif.pc[OFF-1:2];
  assign tag_c  = cif.pc[31:TAG_LSB];
  assign slot_c = mem_addr_q[OFF-1:2];

  assign way_hit_c[0] = cif.fetch_enable && valid_q[0][idx_c] && (tag_q[0][idx_c] == tag_c);
  assign way_hit_c[1] = cif.fetch_enable && valid_q[1][idx_c] && (tag_q[1][idx_c] == tag_c);
  assign bypass_c     = (state_q == REFILL) && cif.mem_valid && (mem_addr_q == cif.pc);

  assign cif.hit      = bypass_c || (|way_hit_c);
  assign cif.hit_data = bypass_c     ? cif.mem_data :
                        way_hit_c[0] ? data_q[0][idx_c][wrd_c] :
                                       data_q[1][idx_c][wrd_c];

  assign cif.mem_enable = mem_enable_q;
  assign cif.mem_addr   = mem_addr_q;
  assign cif.busy       = busy_q;

  // Fill the first invalid way, otherwise evict the way named by the set's LRU bit.
  assign victim_c = !valid_q[0][fill_index_q] ? 1'b0 :
                    !valid_q[1][fill_index_q] ? 1'b1 : lru_q[fill_index_q];

  // Next-state logic: miss detection, word stepping, install and flush abort.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_addr_d   = mem_addr_q;
    busy_d       = busy_q;
    fill_tag_d   = fill_tag_q;
    fill_index_d = fill_index_q;
    buf_d        = buf_q;
    install_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cif.fetch_enable && !cif.hit && !cif.flush) begin
          fill_tag_d   = tag_c;
          fill_index_d = idx_c;
          mem_addr_d   = {cif.pc[31:OFF], OFF'(0)};
          mem_enable_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = REFILL;
        end
      end
      REFILL: begin
        if (cif.flush) begin
          mem_enable_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (cif.mem_valid) begin
          buf_d[slot_c] = cif.mem_data;
          if (slot_c == WORD_OFF_BITS'(WORDS - 1)) begin
            install_c    = 1'b1;
            mem_enable_d = 1'b0;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            mem_addr_d = mem_addr_q + 32'd4;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and memory-request registers; everything holds while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
    end else if (rdy) begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_addr_q   <= mem_addr_d;
      busy_q       <= busy_d;
    end
  end

  // Refill bookkeeping: target set/tag and the partially received line.
  always_ff @(posedge clk) begin
    if (rdy) begin
      fill_tag_q   <= fill_tag_d;
      fill_index_q <= fill_index_d;
      buf_q        <= buf_d;
    end
  end

  // Valid and LRU state: hit touches the set, install marks the new way, flush invalidates.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q      <= '0;
    end else if (rdy) begin
      if (|way_hit_c) lru_q[idx_c] <= way_hit_c[0];
      if (cif.flush) begin
        valid_q[0] <= '0;
        valid_q[1] <= '0;
      end else if (install_c) begin
        valid_q[victim_c][fill_index_q] <= 1'b1;
        lru_q[fill_index_q]             <= ~victim_c;
      end
    end
  end

  // Tag and data arrays; the last word is taken straight from the memory bus.
  always_ff @(posedge clk) begin
    if (!rst && rdy && install_c) begin
      tag_q[victim_c][fill_index_q] <= fill_tag_q;
      for (int unsigned w = 0; w < WORDS; w++) begin
        data_q[victim_c][fill_index_q][WORD_OFF_BITS'(w)] <=
          (w == WORDS - 1) ? cif.mem_data : buf_q[WORD_OFF_BITS'(w)];
      end
    end
  end

endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: stimulus queues expectations, a negedge monitor checks them.
module tb_icache_2way;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  icache_2way_if cif();

  icache_2way #(.INDEX_BITS(6), .WORD_OFF_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .cif (cif)
  );

  typedef struct {
    string       name;
    logic        hit;
    logic [31:0] data;
    logic        men;
    logic        chka;
    logic [31:0] addr;
    logic        busy;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          obs      = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, ex);
    end
  endtask

  // Backing memory contents; the 0x100 line carries the hand-picked words 0x11..0x44.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'h11 * ({30'b0, a[3:2]} + 32'd1);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic expect_now(input string nm, input logic h, input logic [31:0] d,
                            input logic men, input logic chka, input logic [31:0] a,
                            input logic b);
    exp_t e;
    e.name = nm; e.hit = h; e.data = d; e.men = men; e.chka = chka; e.addr = a; e.busy = b;
    exp_q.push_back(e);
    obs = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    obs = 1'b0;
  endtask

  // Monitor: cycle observations and memory handshakes, each against its own queue.
  always @(negedge clk) begin
    exp_t e;
    if (obs) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard: observation with no queued expectation");
      end else begin
        e = exp_q.pop_front();
        cmp({e.name, " hit"}, 32'(cif.hit), 32'(e.hit));
        if (e.hit) cmp({e.name, " hit_data"}, cif.hit_data, e.data);
        cmp({e.name, " mem_enable"}, 32'(cif.mem_enable), 32'(e.men));
        if (e.chka) cmp({e.name, " mem_addr"}, cif.mem_addr, e.addr);
        cmp({e.name, " busy"}, 32'(cif.busy), 32'(e.busy));
      end
    end
    if (rdy && !rst && cif.mem_enable && cif.mem_valid) begin
      if (mem_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL handshake: unexpected request at %h", cif.mem_addr);
      end else begin
        cmp("handshake addr", cif.mem_addr, mem_q.pop_front());
      end
    end
  end

  // Miss on base, then answer each word after one wait cycle; optional flush, stall or reset.
  task automatic refill(input logic [31:0] base, input int flush_w, input bit flush_on_valid,
                        input int stall_w, input int rst_w);
    logic [31:0] a;
    cif.fetch_enable = 1'b1;
    cif.pc           = base;
    rdy              = 1'b1;
    expect_now("miss", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      a = base + 32'(4 * i);
      if (stall_w == i) begin
        rdy = 1'b0;
        for (int s = 0; s < 5; s++) begin
          cif.mem_valid = (s == 2);
          cif.mem_data  = 32'hDEAD_BEEF;
          expect_now("stall", 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b1);
          tick();
        end
        cif.mem_valid = 1'b0;
        rdy           = 1'b1;
      end
      if (rst_w == i) begin
        rst = 1'b1;
        expect_now("pre-reset", 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b1);
        tick();
        rst              = 1'b0;
        cif.fetch_enable = 1'b0;
        expect_now("post-reset", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        tick();
        return;
      end
      if (flush_w == i && !flush_on_valid) begin
        cif.flush = 1'b1;
        expect_now("pre-flush", 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b1);
        tick();
        cif.flush        = 1'b0;
        cif.fetch_enable = 1'b0;
        expect_now("post-flush", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        return;
      end
      expect_now("wait", 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b1);
      tick();
      cif.mem_valid = 1'b1;
      cif.mem_data  = mem_word(a);
      cif.flush     = (flush_w == i);
      mem_q.push_back(a);
      expect_now("word", (a == base), mem_word(a), 1'b1, 1'b1, a, 1'b1);
      tick();
      cif.mem_valid = 1'b0;
      if (cif.flush) begin
        cif.flush        = 1'b0;
        cif.fetch_enable = 1'b0;
        expect_now("post-flush-last", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        return;
      end
    end
    cif.fetch_enable = 1'b0;
    expect_now("done", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
  endtask

  // Side-effect-free lookup: rdy low keeps state and LRU frozen while hit still evaluates.
  task automatic probe(input string nm, input logic [31:0] p, input logic h);
    rdy              = 1'b0;
    cif.fetch_enable = 1'b1;
    cif.pc           = p;
    expect_now(nm, h, mem_word(p), 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    rdy              = 1'b1;
    cif.fetch_enable = 1'b0;
  endtask

  // Real fetch hit with rdy high, so the set's LRU bit is updated.
  task automatic access(input string nm, input logic [31:0] p);
    rdy              = 1'b1;
    cif.fetch_enable = 1'b1;
    cif.pc           = p;
    expect_now(nm, 1'b1, mem_word(p), 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    cif.fetch_enable = 1'b0;
  endtask

  initial begin
    rst              = 1'b1;
    rdy              = 1'b1;
    cif.fetch_enable = 1'b0;
    cif.pc           = 32'h0;
    cif.flush        = 1'b0;
    cif.mem_valid    = 1'b0;
    cif.mem_data     = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    expect_now("reset", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();

    // Cold miss with first-word bypass, then array hits.
    refill(32'h100, -1, 1'b0, -1, -1);
    probe("cold 0x108", 32'h108, 1'b1);
    probe("cold 0x100", 32'h100, 1'b1);
    probe("cold 0x10C", 32'h10C, 1'b1);

    // Two tags in set 0, touch 0x000, a third tag evicts 0x400.
    refill(32'h000, -1, 1'b0, -1, -1);
    refill(32'h400, -1, 1'b0, -1, -1);
    access("touch 0x000", 32'h000);
    refill(32'h800, -1, 1'b0, -1, -1);
    probe("lru 0x000 kept", 32'h000, 1'b1);
    probe("lru 0x400 evicted", 32'h400, 1'b0);
    probe("lru 0x800 in", 32'h808, 1'b1);
    probe("lru 0x104 other set", 32'h104, 1'b1);

    // Flush after two words: abort, and everything is invalid.
    refill(32'h200, 2, 1'b0, -1, -1);
    probe("flush 0x200", 32'h200, 1'b0);
    probe("flush 0x100", 32'h100, 1'b0);
    probe("flush 0x000", 32'h000, 1'b0);

    // Flush on the last word beats the install.
    refill(32'h300, 3, 1'b1, -1, -1);
    probe("flush-last 0x300", 32'h300, 1'b0);

    // rdy stall mid-refill with a stray mem_valid that must be ignored.
    refill(32'h600, -1, 1'b0, 1, -1);
    probe("stall 0x600", 32'h600, 1'b1);
    probe("stall 0x604", 32'h604, 1'b1);
    probe("stall 0x60C", 32'h60C, 1'b1);

    // Reset mid-refill drops the fill and all cached lines.
    refill(32'h500, -1, 1'b0, -1, 1);
    probe("reset 0x600", 32'h600, 1'b0);
    probe("reset 0x500", 32'h500, 1'b0);

    tick();
    checks++;
    if (exp_q.size() != 0 || mem_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d observations and %0d handshakes left unmatched",
               exp_q.size(), mem_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
